vexriscv_ram_arbiter: RTL
=========================

Name: vexriscv_ram_arbiter

Overview:
Shares the data-side port of the VexRiscv on-chip dual-port byte-write RAM between two masters: the CPU dbus and a program/debug loader (UART loader, JTAG bridge).
- The instruction port stays directly connected to the CPU ibus.
- Arbitrates command-level handshakes and converts byte addresses to word addresses.
- Tracks the RAM's 1-cycle read latency and returns each read response to the master that issued it.
- Provides starvation protection and a loader lock for bulk program loads.

Parameters:
NB_COL, 4, byte lanes per word
COL_WIDTH, 8, bits per lane
RAM_DEPTH, 1024, words in RAM; RAM_AW = $clog2(RAM_DEPTH)
MAX_WAIT, 15, cycles a pending loader request may be refused before it wins priority; 0 = loader always wins when valid
DW, NB_COL*COL_WIDTH, data width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dbus_cmd_valid  in  1  CPU command valid
dbus_cmd_ready  out  1  CPU command accepted this cycle
dbus_cmd_wr  in  1  1 = write, 0 = read
dbus_cmd_addr  in  32  CPU byte address
dbus_cmd_data  in  DW  CPU write data
dbus_cmd_mask  in  NB_COL  CPU byte enables
dbus_rsp_valid  out  1  CPU read data valid
dbus_rsp_data  out  DW  CPU read data
ldr_cmd_valid / ldr_cmd_ready / ldr_cmd_wr / ldr_cmd_addr / ldr_cmd_data / ldr_cmd_mask  same directions and widths as dbus_cmd_*  loader command
ldr_lock  in  1  loader exclusive-access request
ldr_rsp_valid  out  1  loader read data valid
ldr_rsp_data  out  DW  loader read data
ram_en  out  1  RAM port enable
ram_we  out  NB_COL  RAM byte write enables
ram_addr  out  RAM_AW  RAM word address
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data, valid 1 cycle after ram_en with ram_we == 0
addr_err  out  1  out-of-range pulse (only with the optional feature)

Behaviour:
- Reset: all outputs are 0 while rst_n is low.
  - wait_cnt = 0; rsp_owner = NONE.
  - An in-flight read response is discarded; no rsp_valid is emitted after reset release.
- Grant (combinational from the registered state plus the current valids), at most one master per cycle. Priority order:
  1. ldr_lock = 1: loader granted; dbus_cmd_ready = 0, even when ldr_cmd_valid = 0.
  2. ldr_cmd_valid && wait_cnt == MAX_WAIT: loader granted.
  3. dbus_cmd_valid: CPU granted.
  4. ldr_cmd_valid: loader granted.
- cmd_ready is high only for the granted master whose valid is high. A command transfers when valid && ready.
- RAM drive on transfer:
  - ram_en = 1.
  - ram_we = mask if wr, else 0.
  - ram_addr = addr[RAM_AW+1:2].
  - ram_din = data.
  - With no transfer: ram_en = 0 and ram_we = 0.
- Addresses are word-aligned by the masters; addr[1:0] is ignored.
- Read transfer: rsp_owner is registered. The next cycle, the owner's rsp_valid = 1 for exactly one cycle and its rsp_data = ram_dout. Back-to-back reads produce back-to-back responses.
- Write transfer: no response.
- rsp_data of the non-owner holds its last value.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle ldr_cmd_valid = 1 and the loader is not granted.
  - Clears on loader transfer or when ldr_cmd_valid = 0.
- Simultaneous CPU and loader requests with wait_cnt < MAX_WAIT: CPU wins.
- ldr_lock deassertion takes effect in the same cycle; the CPU can be granted immediately.
- No combinational path from any rsp_* output to ram_dout other than the registered owner select.

Optional Feature:
VEXRISCV_RAM_ARB_RANGE_CHECK_EN
- Defined: a transfer with addr[31:RAM_AW+2] != 0 is out of range.
  - Writes are suppressed (ram_en = 0, ram_we = 0).
  - Reads still respond next cycle with rsp_data = 0.
  - addr_err pulses 1 for one cycle, registered, aligned with the response slot.
- Undefined: upper address bits are ignored (addresses alias) and addr_err is tied to 0.

Decomposition:
- Package vexriscv_ram_pkg holds:
  - owner_e enum: NONE, CPU, LDR.
  - Defaults for NB_COL, COL_WIDTH, RAM_DEPTH.
  - byte_to_word address function.
- One natural sub-module, vexriscv_ram_rsp_track: a 1-entry owner/valid pipeline plus response demux.

Test Plan:
- Reset mid-read: CPU read issued at addr 0x10, rst_n low the following cycle -> no dbus_rsp_valid; all outputs 0 until rst_n high.
- CPU write then read: write 0xDEADBEEF, mask 4'b0101, addr 0x20 (old word 0) -> read next cycle returns dbus_rsp_data = 0x00AD00EF exactly 1 cycle after transfer.
- Contention: both masters valid continuously, MAX_WAIT = 3 -> CPU granted for 3 cycles, loader granted in the 4th, wait_cnt = 0 afterwards.
- Lock: ldr_lock = 1 with the loader idle and CPU valid -> dbus_cmd_ready = 0 and ram_en = 0; after lock drops, CPU transfers in the same cycle.
- Interleaved reads: CPU read 0x0, loader read 0x4 on consecutive cycles -> dbus_rsp_valid then ldr_rsp_valid on consecutive cycles, each carrying its own word.
- Range check (macro defined, RAM_DEPTH = 1024): write to 0x1000 -> ram_en = 0 and addr_err pulses; read to 0x1000 -> rsp_data = 0 and addr_err = 1.

Source files
------------

// File: rtl/vexriscv_ram_pkg.sv
// Shared types and defaults for the VexRiscv data-side RAM arbiter.
package vexriscv_ram_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        LDR  = 2'd2
    } owner_e;

    localparam int NB_COL_DEF    = 4;
    localparam int COL_WIDTH_DEF = 8;
    localparam int RAM_DEPTH_DEF = 1024;

    // Masters issue byte addresses; the RAM is word addressed.
    function automatic logic [31:0] byte_to_word(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

endpackage

// File: rtl/vexriscv_ram_rsp_track.sv
// One-entry read-owner pipeline; steers ram_dout to the master that issued the read.
module vexriscv_ram_rsp_track
    import vexriscv_ram_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    rd_owner,
    input  logic          xfer_err,
    input  logic [DW-1:0] ram_dout,
    output logic          dbus_rsp_valid,
    output logic [DW-1:0] dbus_rsp_data,
    output logic          ldr_rsp_valid,
    output logic [DW-1:0] ldr_rsp_data,
    output logic          addr_err
);

    owner_e        owner_q;
    logic          err_q;
    logic [DW-1:0] dbus_hold;
    logic [DW-1:0] ldr_hold;
    logic [DW-1:0] rsp_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_e'(rd_owner);
            err_q   <= xfer_err;
        end
    end

    // Out-of-range reads return zero instead of whatever the RAM drives.
    assign rsp_word       = err_q ? '0 : ram_dout;
    assign addr_err       = err_q;

    assign dbus_rsp_valid = (owner_q == CPU);
    assign ldr_rsp_valid  = (owner_q == LDR);
    assign dbus_rsp_data  = dbus_rsp_valid ? rsp_word : dbus_hold;
    assign ldr_rsp_data   = ldr_rsp_valid  ? rsp_word : ldr_hold;

    // Each master's data holds its last response while the other owns the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_hold <= '0;
            ldr_hold  <= '0;
        end else begin
            if (dbus_rsp_valid) dbus_hold <= rsp_word;
            if (ldr_rsp_valid)  ldr_hold  <= rsp_word;
        end
    end

endmodule

// File: rtl/vexriscv_ram_arbiter.sv
// Arbitrates CPU dbus and loader onto the RAM data port.
// Optional VEXRISCV_RAM_ARB_RANGE_CHECK_EN: block out-of-range accesses and flag addr_err.
module vexriscv_ram_arbiter
    import vexriscv_ram_pkg::*;
#(
    parameter int NB_COL    = NB_COL_DEF,
    parameter int COL_WIDTH = COL_WIDTH_DEF,
    parameter int RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int MAX_WAIT  = 15,
    parameter int DW        = NB_COL * COL_WIDTH,
    parameter int RAM_AW    = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              dbus_cmd_valid,
    output logic              dbus_cmd_ready,
    input  logic              dbus_cmd_wr,
    input  logic [31:0]       dbus_cmd_addr,
    input  logic [DW-1:0]     dbus_cmd_data,
    input  logic [NB_COL-1:0] dbus_cmd_mask,
    output logic              dbus_rsp_valid,
    output logic [DW-1:0]     dbus_rsp_data,

    input  logic              ldr_cmd_valid,
    output logic              ldr_cmd_ready,
    input  logic              ldr_cmd_wr,
    input  logic [31:0]       ldr_cmd_addr,
    input  logic [DW-1:0]     ldr_cmd_data,
    input  logic [NB_COL-1:0] ldr_cmd_mask,
    input  logic              ldr_lock,
    output logic              ldr_rsp_valid,
    output logic [DW-1:0]     ldr_rsp_data,

    output logic              ram_en,
    output logic [NB_COL-1:0] ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,

    output logic              addr_err
);

    localparam int             WCW  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

    logic [WCW-1:0]    wait_cnt;
    logic              ldr_due;
    logic              gnt_ldr;
    logic              gnt_cpu;
    logic              cpu_xfer;
    logic              ldr_xfer;
    logic              xfer;
    logic              sel_wr;
    logic [31:0]       sel_addr;
    logic [DW-1:0]     sel_data;
    logic [NB_COL-1:0] sel_mask;
    logic [31:0]       word_addr;
    logic              oor;
    logic              ram_go;
    logic [1:0]        rd_owner;
    logic              unused_addr_bits;

    // A starved loader overrides the CPU; the lock overrides everything.
    assign ldr_due = ldr_cmd_valid && (wait_cnt == WMAX);
    assign gnt_ldr = ldr_lock || ldr_due || (ldr_cmd_valid && !dbus_cmd_valid);
    assign gnt_cpu = !ldr_lock && !ldr_due && dbus_cmd_valid;

    // Gating with rst_n keeps every output low while reset is held.
    assign dbus_cmd_ready = rst_n && gnt_cpu;
    assign ldr_cmd_ready  = rst_n && gnt_ldr && ldr_cmd_valid;
    assign cpu_xfer       = dbus_cmd_ready;
    assign ldr_xfer       = ldr_cmd_ready;
    assign xfer           = cpu_xfer || ldr_xfer;

    assign sel_wr   = ldr_xfer ? ldr_cmd_wr   : dbus_cmd_wr;
    assign sel_addr = ldr_xfer ? ldr_cmd_addr : dbus_cmd_addr;
    assign sel_data = ldr_xfer ? ldr_cmd_data : dbus_cmd_data;
    assign sel_mask = ldr_xfer ? ldr_cmd_mask : dbus_cmd_mask;

    assign word_addr        = byte_to_word(sel_addr);
    assign unused_addr_bits = ^{word_addr[31:RAM_AW], sel_addr[1:0]};

`ifdef VEXRISCV_RAM_ARB_RANGE_CHECK_EN
    assign oor = xfer && (sel_addr[31:RAM_AW+2] != '0);
`else
    assign oor = 1'b0;
`endif

    assign ram_go   = xfer && !oor;
    assign ram_en   = ram_go;
    assign ram_we   = (ram_go && sel_wr) ? sel_mask : '0;
    assign ram_addr = xfer ? word_addr[RAM_AW-1:0] : '0;
    assign ram_din  = xfer ? sel_data : '0;

    always_comb begin
        rd_owner = NONE;
        if (xfer && !sel_wr) rd_owner = ldr_xfer ? LDR : CPU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (!ldr_cmd_valid || ldr_xfer)
            wait_cnt <= '0;
        else if (wait_cnt != WMAX)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // With the range check compiled out, oor is constant 0 so addr_err stays 0.
    vexriscv_ram_rsp_track #(.DW(DW)) u_rsp (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_owner      (rd_owner),
        .xfer_err      (oor),
        .ram_dout      (ram_dout),
        .dbus_rsp_valid(dbus_rsp_valid),
        .dbus_rsp_data (dbus_rsp_data),
        .ldr_rsp_valid (ldr_rsp_valid),
        .ldr_rsp_data  (ldr_rsp_data),
        .addr_err      (addr_err)
    );

endmodule
